// File: rtl/issue_cdb_scheduler_pkg.sv
// Shared types and latency constants for the issue scheduler and the
// execution units that produce results onto the common data bus.
package issue_cdb_scheduler_pkg;

   // Owner of the CDB in a given cycle.
   typedef enum logic [2:0] {
      SRC_NONE = 3'd0,
      SRC_INT  = 3'd1,
      SRC_LS   = 3'd2,
      SRC_MULT = 3'd3,
      SRC_DIV  = 3'd4
   } cdb_src_e;

   // Cycles from grant to CDB ownership for each unit class.
   localparam int INT_LAT  = 1;
   localparam int MULT_LAT = 4;
   localparam int DIV_LAT  = 7;

endpackage

// File: rtl/issue_cdb_scheduler_if.sv
// Handshake bundle between the reservation queues, the scheduler and the
// CDB consumers. The scheduler side takes the master modport.
interface issue_cdb_scheduler_if;
   import issue_cdb_scheduler_pkg::*;

   logic     flush;
   logic     int_ready;
   logic     ls_ready;
   logic     mult_ready;
   logic     div_ready;
   logic     int_issue;
   logic     ls_issue;
   logic     mult_issue;
   logic     div_issue;
   logic     div_busy;
   logic     cdb_valid;
   cdb_src_e cdb_src;

   modport master (
      input  flush, int_ready, ls_ready, mult_ready, div_ready,
      output int_issue, ls_issue, mult_issue, div_issue,
             div_busy, cdb_valid, cdb_src
   );

   modport slave (
      output flush, int_ready, ls_ready, mult_ready, div_ready,
      input  int_issue, ls_issue, mult_issue, div_issue,
             div_busy, cdb_valid, cdb_src
   );

endinterface

// File: rtl/cdb_reservation_sr.sv
// CDB reservation table: slot[k] names the unit that owns the bus k cycles
// from now. Shifts toward slot[0] every cycle; grants are written into the
// slot one below their latency so they land on slot[0] exactly on time.
module cdb_reservation_sr
   import issue_cdb_scheduler_pkg::*;
#(
   parameter int DEPTH    = 7,
   parameter int MULT_POS = 3,
   parameter int IL_POS   = 0
) (
   input  logic     clk,
   input  logic     rst_n,
   input  logic     div_ins,
   input  logic     mult_ins,
   input  logic     il_ins,
   input  cdb_src_e il_src,
   output cdb_src_e slot [0:DEPTH]
);

   // Advance the table one cycle, then drop in this cycle's reservations.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k <= DEPTH; k++) begin
            slot[k] <= SRC_NONE;
         end
      end else begin
         for (int k = 0; k < DEPTH; k++) begin
            slot[k] <= slot[k+1];
         end
         slot[DEPTH] <= SRC_NONE;
         if (div_ins) begin
            slot[DEPTH-1] <= SRC_DIV;
         end
         if (mult_ins) begin
            slot[MULT_POS] <= SRC_MULT;
         end
         if (il_ins) begin
            slot[IL_POS] <= il_src;
         end
      end
   end

endmodule

// File: rtl/issue_cdb_scheduler.sv
// Issue scheduler: grants at most one issue per reservation queue per cycle
// and books the CDB cycle of every granted result so writebacks never
// collide. The divider is non-pipelined, the multiplier pipelined, and
// int / lw-sw share one single-cycle CDB slot arbitrated round-robin.
module issue_cdb_scheduler #(
   parameter int INT_LAT  = issue_cdb_scheduler_pkg::INT_LAT,
   parameter int MULT_LAT = issue_cdb_scheduler_pkg::MULT_LAT,
   parameter int DIV_LAT  = issue_cdb_scheduler_pkg::DIV_LAT
) (
   input  logic                  clk,
   input  logic                  rst_n,
   issue_cdb_scheduler_if.master bus
);
   import issue_cdb_scheduler_pkg::*;

   localparam int CNT_W = $clog2(DIV_LAT);

   if (!(MULT_LAT > 1 && MULT_LAT < DIV_LAT && INT_LAT >= 1 && INT_LAT < MULT_LAT)) begin : g_bad_lat
      $error("issue_cdb_scheduler: latencies must satisfy 1 <= INT_LAT < MULT_LAT < DIV_LAT, MULT_LAT > 1");
   end

   cdb_src_e             slot [0:DIV_LAT];
   logic [CNT_W-1:0]     div_cnt;
   logic                 rr_ls;
   logic                 int_g;
   logic                 ls_g;
   logic                 mult_g;
   logic                 div_g;
   logic                 il_ok;
   logic                 both_il;

   cdb_reservation_sr #(
      .DEPTH    (DIV_LAT),
      .MULT_POS (MULT_LAT - 1),
      .IL_POS   (INT_LAT - 1)
   ) u_sr (
      .clk      (clk),
      .rst_n    (rst_n),
      .div_ins  (div_g),
      .mult_ins (mult_g),
      .il_ins   (int_g | ls_g),
      .il_src   (int_g ? SRC_INT : SRC_LS),
      .slot     (slot)
   );

   assign both_il = bus.int_ready & bus.ls_ready;

   // Same-cycle grants from table state and queue readiness; gated off in reset.
   always_comb begin
      int_g  = 1'b0;
      ls_g   = 1'b0;
      div_g  = rst_n & ~bus.flush & bus.div_ready & (div_cnt == '0)
               & (slot[DIV_LAT] == SRC_NONE);
      mult_g = rst_n & ~bus.flush & bus.mult_ready & (slot[MULT_LAT] == SRC_NONE);
      il_ok  = rst_n & ~bus.flush & (slot[INT_LAT] == SRC_NONE);
      if (il_ok) begin
         if (both_il) begin
            if (rr_ls) begin
               ls_g = 1'b1;
            end else begin
               int_g = 1'b1;
            end
         end else if (bus.int_ready) begin
            int_g = 1'b1;
         end else if (bus.ls_ready) begin
            ls_g = 1'b1;
         end
      end
   end

   // Round-robin pointer moves only when int and lw/sw actually contended.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rr_ls <= 1'b0;
      end else if (both_il && (int_g || ls_g)) begin
         rr_ls <= ~rr_ls;
      end
   end

   // Divider occupancy: reload on grant, otherwise count down to idle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         div_cnt <= '0;
      end else if (div_g) begin
         div_cnt <= CNT_W'(DIV_LAT - 1);
      end else if (div_cnt != '0) begin
         div_cnt <= div_cnt - 1'b1;
      end
   end

   assign bus.int_issue  = int_g;
   assign bus.ls_issue   = ls_g;
   assign bus.mult_issue = mult_g;
   assign bus.div_issue  = div_g;
   assign bus.div_busy   = (div_cnt != '0);
   assign bus.cdb_src    = slot[0];
   assign bus.cdb_valid  = (slot[0] != SRC_NONE);

endmodule
